// File: rtl/memory_request_arbiter.sv
// Round-robin arbiter sharing one memory controller port among NUM_REQ requesters.
// Optional stall counter output is enabled by defining ARB_STALL_COUNT_EN.

// In-order tag FIFO holding the requester ID of every read in flight.
// Latency: head visible combinationally; push/pop take effect at the next edge.
// Backpressure: caller must not push when full unless popping in the same cycle.
module arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
endmodule

// Shares the memory controller port: round-robin, pipelined reads, writes wait for reads to drain.
// Latency: grant/issue and response routing are combinational (0 cycles).
// Backpressure: mem_busy or a full tag FIFO holds requests; the blocked winner keeps priority.
module memory_request_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_OUTSTND = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_read,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][27:0] req_addr,
    input  logic [NUM_REQ-1:0][31:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [27:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_busy,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_rdata_valid,
    output logic                     err_orphan_rsp
`ifdef ARB_STALL_COUNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int IDW1 = IDW + 1;
    localparam logic [IDW1-1:0] NREQ_W  = IDW1'(NUM_REQ);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(NUM_REQ - 1);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [IDW-1:0]    r_drain_id;
    logic [IDW-1:0]    w_drain_id_nxt;
    logic              r_orphan;

    logic [NUM_REQ-1:0] w_req_any;
    logic [IDW1-1:0]    w_scan;
    logic [IDW-1:0]     w_win;
    logic               w_found;
    logic               w_issue_rd;
    logic               w_issue_wr;
    logic               w_issue;
    logic [IDW-1:0]     w_gnt_id;
    logic               w_pop;
    logic [IDW-1:0]     w_head_id;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    function automatic logic [IDW-1:0] f_next_id(input logic [IDW-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    assign w_req_any = req_read | req_write;

    // Scan upward from the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_ptr} + IDW1'(i);
            if (w_scan >= NREQ_W)
                w_scan = w_scan - NREQ_W;
            if (!w_found && w_req_any[w_scan[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[IDW-1:0];
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a read.
    assign w_pop = rst_n && mem_rdata_valid && !w_fifo_empty;

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_drain_id_nxt = r_drain_id;
        w_issue_rd     = 1'b0;
        w_issue_wr     = 1'b0;
        w_gnt_id       = '0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (w_found) begin
                        if (req_write[w_win]) begin
                            if (!w_fifo_empty) begin
                                // Older reads in flight: hold the write until they return.
                                w_state_nxt    = ST_DRAIN;
                                w_drain_id_nxt = w_win;
                            end else if (!mem_busy) begin
                                w_issue_wr = 1'b1;
                                w_gnt_id   = w_win;
                                w_ptr_nxt  = f_next_id(w_win);
                            end
                        end else if (!mem_busy && (!w_fifo_full || w_pop)) begin
                            w_issue_rd = 1'b1;
                            w_gnt_id   = w_win;
                            w_ptr_nxt  = f_next_id(w_win);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_fifo_empty && !mem_busy) begin
                        w_issue_wr  = 1'b1;
                        w_gnt_id    = r_drain_id;
                        w_ptr_nxt   = f_next_id(r_drain_id);
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign w_issue = w_issue_rd | w_issue_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_ptr      <= '0;
            r_drain_id <= '0;
            r_orphan   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_drain_id <= w_drain_id_nxt;
            if (mem_rdata_valid && w_fifo_empty)
                r_orphan <= 1'b1;
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTND),
        .W     (IDW)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_issue_rd),
        .i_push_dat (w_gnt_id),
        .i_pop      (w_pop),
        .o_head_dat (w_head_id),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign req_grant      = w_issue ? (NUM_REQ'(1) << w_gnt_id) : '0;
    assign mem_read       = w_issue_rd;
    assign mem_write      = w_issue_wr;
    assign mem_addr       = w_issue ? req_addr[w_gnt_id] : '0;
    assign mem_wdata      = w_issue_wr ? req_wdata[w_gnt_id] : '0;
    assign rsp_valid      = w_pop ? (NUM_REQ'(1) << w_head_id) : '0;
    assign rsp_data       = w_pop ? mem_rdata : '0;
    assign err_orphan_rsp = r_orphan;

`ifdef ARB_STALL_COUNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall <= '0;
        else if ((|w_req_any) && !w_issue && (r_stall != 32'hFFFF_FFFF))
            r_stall <= r_stall + 32'd1;
    end

    assign stall_cycles = r_stall;
`else
    // No stall accounting in this build.
`endif
endmodule

// File: tb/tb_memory_request_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's outputs, a negedge monitor checks them.
module tb_memory_request_arbiter;
    localparam int NR = 4;
    localparam int MO = 8;

    typedef struct {
        logic [NR-1:0] gnt;
        logic          rd;
        logic          wr;
        logic [27:0]   addr;
        logic [31:0]   wdata;
        logic [NR-1:0] rsp;
        logic [31:0]   rdata;
        logic          orphan;
        logic [31:0]   stall;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NR-1:0]       req_read, req_write, req_grant, rsp_valid;
    logic [NR-1:0][27:0] req_addr;
    logic [NR-1:0][31:0] req_wdata;
    logic [31:0]         rsp_data, mem_wdata, mem_rdata;
    logic [27:0]         mem_addr;
    logic                mem_read, mem_write, mem_busy, mem_rdata_valid, err_orphan_rsp;
`ifdef ARB_STALL_COUNT_EN
    logic [31:0]         stall_cycles;
`endif

    memory_request_arbiter #(.NUM_REQ(NR), .MAX_OUTSTND(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .err_orphan_rsp(err_orphan_rsp)
`ifdef ARB_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];

    // Requester intentions (held until the model grants them) and memory-side stimulus.
    bit          m_rd[NR], m_wr[NR];
    logic [27:0] m_addr[NR];
    logic [31:0] m_wdata[NR];
    bit          b_busy, b_rv;
    logic [31:0] b_rdata;

    // Reference model state.
    int          tags[$];
    int          rr;
    bit          draining;
    int          drain_id;
    bit          orphan;
    logic [31:0] stall;

    task automatic model_reset();
        tags.delete();
        rr = 0; draining = 0; drain_id = 0; orphan = 0; stall = '0;
        for (int i = 0; i < NR; i++) begin m_rd[i] = 0; m_wr[i] = 0; end
        b_busy = 0; b_rv = 0; b_rdata = '0;
    endtask

    task automatic cycle();
        exp_t e;
        int   w, gid;
        bit   found, pop, iss_rd, iss_wr, any;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            req_read[i]  = m_rd[i];
            req_write[i] = m_wr[i];
            req_addr[i]  = m_addr[i];
            req_wdata[i] = m_wdata[i];
        end
        mem_busy = b_busy; mem_rdata_valid = b_rv; mem_rdata = b_rdata;

        pop = b_rv && (tags.size() > 0);
        iss_rd = 0; iss_wr = 0; gid = 0; w = 0; found = 0; any = 0;
        for (int i = 0; i < NR; i++) any |= (m_rd[i] | m_wr[i]);
        if (!draining) begin
            for (int k = 0; k < NR; k++) begin
                int id;
                id = (rr + k) % NR;
                if (!found && (m_rd[id] || m_wr[id])) begin found = 1; w = id; end
            end
            if (found) begin
                if (m_wr[w]) begin
                    if (tags.size() != 0) begin draining = 1; drain_id = w; end
                    else if (!b_busy) begin iss_wr = 1; gid = w; end
                end else if (!b_busy && (tags.size() < MO || pop)) begin
                    iss_rd = 1; gid = w;
                end
            end
        end else if (tags.size() == 0 && !b_busy) begin
            iss_wr = 1; gid = drain_id; draining = 0;
        end

        e.gnt    = (iss_rd || iss_wr) ? NR'(1) << gid : '0;
        e.rd     = iss_rd;
        e.wr     = iss_wr;
        e.addr   = m_addr[gid];
        e.wdata  = m_wdata[gid];
        e.rsp    = pop ? NR'(1) << tags[0] : '0;
        e.rdata  = b_rdata;
        e.orphan = orphan;
        e.stall  = stall;
        exp_q.push_back(e);

        if (pop) void'(tags.pop_front());
        if (iss_rd) begin tags.push_back(gid); m_rd[gid] = 0; end
        if (iss_wr) m_wr[gid] = 0;
        if (iss_rd || iss_wr) rr = (gid + 1) % NR;
        if (b_rv && !pop) orphan = 1;
        if (any && !(iss_rd || iss_wr) && stall != 32'hFFFF_FFFF) stall = stall + 1;
    endtask

    task automatic set_op(int i, bit rd, bit wr);
        m_rd[i] = rd; m_wr[i] = wr;
        m_addr[i] = 28'($urandom); m_wdata[i] = $urandom;
    endtask

    task automatic rand_reqs(int pct);
        for (int i = 0; i < NR; i++) begin
            if (!m_rd[i] && !m_wr[i] && $urandom_range(99) < pct) begin
                int k;
                k = $urandom_range(3);
                set_op(i, k != 1, (k == 1) || (k == 2));
            end
        end
    endtask

    // Let all pending requests be granted and all reads return.
    task automatic settle();
        b_busy = 0;
        for (int n = 0; n < 80; n++) begin
            bit any;
            any = tags.size() > 0;
            for (int i = 0; i < NR; i++) any |= (m_rd[i] | m_wr[i]);
            if (!any) break;
            b_rv = tags.size() > 0; b_rdata = $urandom;
            cycle();
        end
        b_rv = 0;
    endtask

    task automatic check_idle(string name);
        bit bad;
        bad = (req_grant !== '0) || (rsp_valid !== '0) || (rsp_data !== '0) || (mem_read !== 1'b0) ||
              (mem_write !== 1'b0) || (mem_addr !== '0) || (mem_wdata !== '0) || (err_orphan_rsp !== 1'b0);
`ifdef ARB_STALL_COUNT_EN
        bad |= (stall_cycles !== '0);
`endif
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s: gnt=%b rsp=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h orphan=%b, required all zero",
                     name, req_grant, rsp_valid, rsp_data, mem_read, mem_write, mem_addr, mem_wdata, err_orphan_rsp);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (req_grant !== mon_e.gnt || mem_read !== mon_e.rd || mem_write !== mon_e.wr ||
                ((mon_e.rd || mon_e.wr) && mem_addr !== mon_e.addr) || (mon_e.wr && mem_wdata !== mon_e.wdata)) begin
                n_fail++;
                $display("FAIL issue @%0t: gnt=%b rd=%b wr=%b addr=%h wdata=%h, required gnt=%b rd=%b wr=%b addr=%h wdata=%h",
                         $time, req_grant, mem_read, mem_write, mem_addr, mem_wdata,
                         mon_e.gnt, mon_e.rd, mon_e.wr, mon_e.addr, mon_e.wdata);
            end
            n_tests++;
            if (rsp_valid !== mon_e.rsp || (mon_e.rsp != '0 && rsp_data !== mon_e.rdata)) begin
                n_fail++;
                $display("FAIL response @%0t: rsp_valid=%b data=%h, required rsp_valid=%b data=%h",
                         $time, rsp_valid, rsp_data, mon_e.rsp, mon_e.rdata);
            end
            n_tests++;
            if (err_orphan_rsp !== mon_e.orphan) begin
                n_fail++;
                $display("FAIL orphan @%0t: got %b, required %b", $time, err_orphan_rsp, mon_e.orphan);
            end
`ifdef ARB_STALL_COUNT_EN
            n_tests++;
            if (stall_cycles !== mon_e.stall) begin
                n_fail++;
                $display("FAIL stall @%0t: got %0d, required %0d", $time, stall_cycles, mon_e.stall);
            end
`endif
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin m_addr[i] = '0; m_wdata[i] = '0; end
        model_reset();
        rst_n = 0;
        req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        mem_busy = 0; mem_rdata_valid = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #2 check_idle("reset_state");
        @(negedge clk) rst_n = 1;

        // Single read and its return.
        m_rd[0] = 1; m_addr[0] = 28'h100; m_wdata[0] = '0;
        cycle();
        b_rv = 1; b_rdata = 32'hCAFE;
        cycle();
        b_rv = 0;

        // All requesters reading continuously with returns flowing.
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NR; i++) if (!m_rd[i] && !m_wr[i]) set_op(i, 1, 0);
            b_rv = tags.size() > 0; b_rdata = $urandom;
            cycle();
        end
        settle();

        // Fill the tag FIFO, stall the 9th read, then pop and push together.
        for (int n = 0; n < 11; n++) begin
            for (int i = 0; i < NR; i++) if (!m_rd[i] && !m_wr[i]) set_op(i, 1, 0);
            cycle();
        end
        b_rv = 1; b_rdata = 32'h1234_5678;
        cycle();
        b_rv = 0;
        cycle();
        settle();

        // Write behind two outstanding reads must wait for both returns.
        set_op(1, 1, 0); set_op(2, 1, 0);
        for (int n = 0; n < 4 && (m_rd[1] || m_rd[2]); n++) cycle();
        set_op(0, 0, 1);
        cycle();
        cycle();
        b_rv = 1; b_rdata = 32'hAAAA_0001; cycle();
        b_rv = 1; b_rdata = 32'hAAAA_0002; cycle();
        b_rv = 0;
        cycle();
        cycle();
        settle();

        // Busy controller blocks a read for five cycles.
        set_op(3, 1, 0);
        b_busy = 1;
        repeat (5) cycle();
        b_busy = 0;
        cycle();
        settle();

        // Read and write on the same requester: write first, read stays pending.
        set_op(2, 1, 1);
        repeat (3) cycle();
        settle();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            rand_reqs(40);
            b_busy  = $urandom_range(99) < 20;
            b_rv    = (tags.size() > 0) && ($urandom_range(99) < 45);
            b_rdata = $urandom;
            cycle();
        end
        settle();

        // Orphan return, then reset in the middle of traffic, then a late return.
        b_rv = 1; b_rdata = 32'hDEAD_BEEF;
        cycle();
        b_rv = 0;
        cycle();
        for (int i = 0; i < NR; i++) set_op(i, 1, 0);
        repeat (3) cycle();
        @(posedge clk);
        #2 rst_n = 0;
        #1 check_idle("reset_mid_traffic");
        req_read = '0; req_write = '0; mem_rdata_valid = 0; mem_busy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        b_rv = 1; b_rdata = 32'h0BAD_0BAD;
        cycle();
        b_rv = 0;
        cycle();
        cycle();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
